// File: rtl/qam_demap_stream_if.sv
// ---------------------------------------------------------------------------
// qam_demap_stream_if
// Bundles the sample stream and metric signals of the QAM hard-decision
// demapper.
//   master : upstream/downstream environment. It drives the input samples and
//            out_ready, and it observes the demapped outputs and the metric.
//   slave  : the demapper itself.
// Signals:
//   in_valid/in_ready/in_re/in_im/in_mode/in_last  - input sample handshake
//   out_valid/out_ready/out_bits/out_re/out_im/
//   out_err/out_last                               - output sample handshake
//   metric_valid/metric                            - per-frame L1 error metric
// ---------------------------------------------------------------------------
interface qam_demap_stream_if #(
    parameter int IN_W  = 22,
    parameter int OUT_W = 13,
    parameter int ERR_W = 32
) ();
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_re;
    logic signed [IN_W-1:0]  in_im;
    logic [1:0]              in_mode;
    logic                    in_last;

    logic                    out_valid;
    logic                    out_ready;
    logic [5:0]              out_bits;
    logic signed [OUT_W-1:0] out_re;
    logic signed [OUT_W-1:0] out_im;
    logic [IN_W:0]           out_err;
    logic                    out_last;

    logic                    metric_valid;
    logic [ERR_W-1:0]        metric;

    modport master (
        output in_valid, in_re, in_im, in_mode, in_last, out_ready,
        input  in_ready, out_valid, out_bits, out_re, out_im, out_err,
               out_last, metric_valid, metric
    );

    modport slave (
        input  in_valid, in_re, in_im, in_mode, in_last, out_ready,
        output in_ready, out_valid, out_bits, out_re, out_im, out_err,
               out_last, metric_valid, metric
    );
endinterface

// File: rtl/qam_demap_stream.sv
// ---------------------------------------------------------------------------
// qam_demap_stream
// Pipelined hard-decision demapper for QPSK, 16-QAM and 64-QAM. For each
// equalised I/Q sample it slices both axes to the nearest constellation
// level, emits the Gray-coded bits, the sliced point and the L1 slicing
// error, and it accumulates the error over a frame into a link metric.
// Ports:
//   clk - clock
//   rst - synchronous active-high reset
//   bus - qam_demap_stream_if.slave (sample in, sample out, metric)
// Pipeline:
//   stage 1 - per-axis region index, mode, raw sample and last flag
//   stage 2 - bits, levels, error and last flag (these drive the outputs)
// Both stages advance together whenever the output is not stalled. A stall
// freezes the whole pipe, so samples are never dropped or duplicated.
// ---------------------------------------------------------------------------
module qam_demap_stream #(
    parameter int IN_W  = 22,
    parameter int OUT_W = 13,
    parameter int A     = 161,
    parameter int ERR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    qam_demap_stream_if.slave bus
);

    localparam logic [1:0] MODE_QPSK = 2'b00;
    localparam logic [1:0] MODE_16   = 2'b01;
    localparam logic [1:0] MODE_64   = 2'b10;

    // Number of levels per axis for a (normalised) mode.
    function automatic int levels_of(input logic [1:0] mode);
        int m;
        case (mode)
            MODE_QPSK: m = 2;
            MODE_64:   m = 8;
            default:   m = 4;
        endcase
        return m;
    endfunction

    // Region index: count of thresholds (2j-M+2)*A that x reaches. Because the
    // comparison is >=, a value sitting exactly on a threshold lands in the
    // upper region. Out-of-range inputs simply count all or none of the
    // thresholds.
    function automatic logic [2:0] slice_idx(input logic signed [IN_W-1:0] x,
                                             input logic [1:0]             mode);
        int         m;
        int         xi;
        int         th;
        logic [2:0] k;
        m  = levels_of(mode);
        xi = int'(x);
        k  = 3'd0;
        for (int j = 0; j < 7; j++) begin
            th = (2 * j - m + 2) * A;
            if ((j < m - 1) && (xi >= th)) begin
                k = k + 3'd1;
            end else begin
                k = k;
            end
        end
        return k;
    endfunction

    // Sliced level (2k-M+1)*A; the largest magnitude (7*A) fits in OUT_W bits.
    function automatic logic signed [OUT_W-1:0] level_of(input logic [2:0] k,
                                                         input logic [1:0] mode);
        return OUT_W'((2 * int'(k) - levels_of(mode) + 1) * A);
    endfunction

    // The imaginary axis counts from the most positive level, so its index is
    // mirrored before Gray coding.
    function automatic logic [2:0] mirror_idx(input logic [2:0] k,
                                              input logic [1:0] mode);
        return 3'(levels_of(mode) - 1 - int'(k));
    endfunction

    // Binary-reflected Gray code. The 1-, 2- and 3-bit tables are the low bits
    // of the same code.
    function automatic logic [2:0] gray_of(input logic [2:0] idx);
        return idx ^ {1'b0, idx[2:1]};
    endfunction

    // Right-aligned {real_gray, imag_gray}; unused MSBs are zero.
    function automatic logic [5:0] pack_bits(input logic [2:0] gr,
                                             input logic [2:0] gi,
                                             input logic [1:0] mode);
        logic [5:0] b;
        case (mode)
            MODE_QPSK: b = {4'b0000, gr[0], gi[0]};
            MODE_64:   b = {gr, gi};
            default:   b = {2'b00, gr[1:0], gi[1:0]};
        endcase
        return b;
    endfunction

    // |x - level| at full precision. The level is sign-extended to IN_W, and
    // one extra bit holds the difference. The magnitude never exceeds
    // 2^(IN_W-1) + 7*A, so the final result fits in IN_W+1 bits.
    function automatic logic [IN_W:0] abs_diff(input logic signed [IN_W-1:0]  x,
                                               input logic signed [OUT_W-1:0] lvl);
        logic signed [IN_W-1:0] lvl_ext;
        logic signed [IN_W:0]   d;
        lvl_ext = {{(IN_W - OUT_W){lvl[OUT_W-1]}}, lvl};
        d       = {x[IN_W-1], x} - {lvl_ext[IN_W-1], lvl_ext};
        return d[IN_W] ? (-d) : d;
    endfunction

    // Pipeline state
    logic                    s1_valid_q, s1_valid_d;
    logic [2:0]              s1_kre_q,   s1_kre_d;
    logic [2:0]              s1_kim_q,   s1_kim_d;
    logic [1:0]              s1_mode_q,  s1_mode_d;
    logic signed [IN_W-1:0]  s1_re_q,    s1_re_d;
    logic signed [IN_W-1:0]  s1_im_q,    s1_im_d;
    logic                    s1_last_q,  s1_last_d;

    logic                    out_valid_q, out_valid_d;
    logic [5:0]              out_bits_q,  out_bits_d;
    logic signed [OUT_W-1:0] out_re_q,    out_re_d;
    logic signed [OUT_W-1:0] out_im_q,    out_im_d;
    logic [IN_W:0]           out_err_q,   out_err_d;
    logic                    out_last_q,  out_last_d;

    logic [ERR_W-1:0]        acc_q,          acc_d;
    logic [ERR_W-1:0]        metric_q,       metric_d;
    logic                    metric_valid_q, metric_valid_d;

    // Combinational helpers
    logic                    en_s;
    logic                    out_xfer_s;
    logic [1:0]              mode_norm_s;
    logic signed [OUT_W-1:0] lvl_re_s;
    logic signed [OUT_W-1:0] lvl_im_s;
    logic [IN_W:0]           err_s;
    logic [ERR_W:0]          acc_sum_s;
    logic [ERR_W-1:0]        acc_sat_s;

    // Handshake: the pipe advances unless a valid output is being held back.
    always_comb begin
        en_s       = !(out_valid_q && !bus.out_ready);
        out_xfer_s = out_valid_q && bus.out_ready;
    end

    // Stage 1 next state: slice both axes and capture the sample with its mode.
    always_comb begin
        mode_norm_s = (bus.in_mode == 2'b11) ? MODE_16 : bus.in_mode;
        if (en_s) begin
            s1_valid_d = bus.in_valid;
            s1_kre_d   = slice_idx(bus.in_re, mode_norm_s);
            s1_kim_d   = slice_idx(bus.in_im, mode_norm_s);
            s1_mode_d  = mode_norm_s;
            s1_re_d    = bus.in_re;
            s1_im_d    = bus.in_im;
            s1_last_d  = bus.in_last;
        end else begin
            s1_valid_d = s1_valid_q;
            s1_kre_d   = s1_kre_q;
            s1_kim_d   = s1_kim_q;
            s1_mode_d  = s1_mode_q;
            s1_re_d    = s1_re_q;
            s1_im_d    = s1_im_q;
            s1_last_d  = s1_last_q;
        end
    end

    // Stage 2 next state: map the indices to levels, Gray bits and the L1 error.
    always_comb begin
        lvl_re_s = level_of(s1_kre_q, s1_mode_q);
        lvl_im_s = level_of(s1_kim_q, s1_mode_q);
        err_s    = abs_diff(s1_re_q, lvl_re_s) + abs_diff(s1_im_q, lvl_im_s);
        if (en_s) begin
            out_valid_d = s1_valid_q;
            out_bits_d  = pack_bits(gray_of(s1_kre_q),
                                    gray_of(mirror_idx(s1_kim_q, s1_mode_q)),
                                    s1_mode_q);
            out_re_d    = lvl_re_s;
            out_im_d    = lvl_im_s;
            out_err_d   = err_s;
            out_last_d  = s1_last_q;
        end else begin
            out_valid_d = out_valid_q;
            out_bits_d  = out_bits_q;
            out_re_d    = out_re_q;
            out_im_d    = out_im_q;
            out_err_d   = out_err_q;
            out_last_d  = out_last_q;
        end
    end

    // Frame metric: saturating accumulation on each output transfer. The
    // last sample of a frame publishes the total and restarts the accumulator.
    always_comb begin
        acc_sum_s      = {1'b0, acc_q} + {{(ERR_W - IN_W){1'b0}}, out_err_q};
        acc_sat_s      = acc_sum_s[ERR_W] ? {ERR_W{1'b1}} : acc_sum_s[ERR_W-1:0];
        acc_d          = acc_q;
        metric_d       = metric_q;
        metric_valid_d = 1'b0;
        if (out_xfer_s) begin
            if (out_last_q) begin
                metric_d       = acc_sat_s;
                metric_valid_d = 1'b1;
                acc_d          = {ERR_W{1'b0}};
            end else begin
                acc_d          = acc_sat_s;
            end
        end else begin
            acc_d          = acc_q;
        end
    end

    // State registers with synchronous reset; reset drops in-flight samples
    // and any partial frame metric.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q     <= 1'b0;
            s1_kre_q       <= 3'd0;
            s1_kim_q       <= 3'd0;
            s1_mode_q      <= 2'b00;
            s1_re_q        <= {IN_W{1'b0}};
            s1_im_q        <= {IN_W{1'b0}};
            s1_last_q      <= 1'b0;
            out_valid_q    <= 1'b0;
            out_bits_q     <= 6'b000000;
            out_re_q       <= {OUT_W{1'b0}};
            out_im_q       <= {OUT_W{1'b0}};
            out_err_q      <= {(IN_W + 1){1'b0}};
            out_last_q     <= 1'b0;
            acc_q          <= {ERR_W{1'b0}};
            metric_q       <= {ERR_W{1'b0}};
            metric_valid_q <= 1'b0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_kre_q       <= s1_kre_d;
            s1_kim_q       <= s1_kim_d;
            s1_mode_q      <= s1_mode_d;
            s1_re_q        <= s1_re_d;
            s1_im_q        <= s1_im_d;
            s1_last_q      <= s1_last_d;
            out_valid_q    <= out_valid_d;
            out_bits_q     <= out_bits_d;
            out_re_q       <= out_re_d;
            out_im_q       <= out_im_d;
            out_err_q      <= out_err_d;
            out_last_q     <= out_last_d;
            acc_q          <= acc_d;
            metric_q       <= metric_d;
            metric_valid_q <= metric_valid_d;
        end
    end

    // Output drive
    always_comb begin
        bus.in_ready     = en_s;
        bus.out_valid    = out_valid_q;
        bus.out_bits     = out_bits_q;
        bus.out_re       = out_re_q;
        bus.out_im       = out_im_q;
        bus.out_err      = out_err_q;
        bus.out_last     = out_last_q;
        bus.metric_valid = metric_valid_q;
        bus.metric       = metric_q;
    end

endmodule

// File: tb/tb_qam_demap_stream.sv
// Self-checking bench for qam_demap_stream. It applies directed points with
// known answers, then runs a random stream with backpressure against a
// nearest-level reference model, and it exercises reset in the middle of a
// frame.
module tb_qam_demap_stream;
    localparam int IN_W  = 22;
    localparam int OUT_W = 13;
    localparam int ERR_W = 32;
    localparam int A_C   = 161;

    typedef struct {
        logic [5:0] bits;
        int         re;
        int         im;
        int         err;
        logic       last;
        int         acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qam_demap_stream_if #(.IN_W(IN_W), .OUT_W(OUT_W), .ERR_W(ERR_W)) bus ();

    qam_demap_stream #(.IN_W(IN_W), .OUT_W(OUT_W), .A(A_C), .ERR_W(ERR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int      vectors     = 0;
    int      miscompares = 0;
    int      cyc         = 0;
    int      outs        = 0;
    exp_t    exp_q[$];
    exp_t    pend;
    bit      accepted    = 1'b0;
    bit      chk_lat     = 1'b0;
    bit      rand_rdy    = 1'b0;
    bit      mv_exp      = 1'b0;
    longint  acc_m       = 0;
    longint  metric_exp  = 0;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: nearest odd multiple of A, clamped to the constellation edge.
    // Ties at even multiples round upward (floor division).
    function automatic int axis_k(input int x, input int m);
        int q;
        q = x / (2 * A_C);
        if ((x % (2 * A_C)) != 0 && x < 0) q = q - 1;
        q = q + m / 2;
        if (q < 0) q = 0;
        if (q > m - 1) q = m - 1;
        return q;
    endfunction

    function automatic int gray_tab(input int i, input int m);
        int g3[8];
        int g2[4];
        g3 = '{0, 1, 3, 2, 6, 7, 5, 4};
        g2 = '{0, 1, 3, 2};
        if (m == 8) return g3[i];
        if (m == 4) return g2[i];
        return i;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic exp_t model(input int re, input int im, input logic [1:0] mode,
                                   input logic last);
        exp_t e;
        int m, nb, kr, ki, lr, li, gr, gi;
        m  = (mode == 2'b00) ? 2 : (mode == 2'b10) ? 8 : 4;
        nb = (m == 2) ? 1 : (m == 4) ? 2 : 3;
        kr = axis_k(re, m);
        ki = axis_k(im, m);
        lr = (2 * kr - m + 1) * A_C;
        li = (2 * ki - m + 1) * A_C;
        gr = gray_tab(kr, m);
        gi = gray_tab(m - 1 - ki, m);
        e.bits    = 6'((gr << nb) | gi);
        e.re      = lr;
        e.im      = li;
        e.err     = iabs(re - lr) + iabs(im - li);
        e.last    = last;
        e.acc_cyc = 0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [5:0] bits, input int re, input int im,
                                input int err, input logic last);
        exp_t e;
        e.bits = bits; e.re = re; e.im = im; e.err = err; e.last = last; e.acc_cyc = 0;
        return e;
    endfunction

    // One clock: check at the falling edge and update the model, then advance
    // past the rising edge.
    task automatic cycle();
        exp_t e;
        longint s;
        if (rand_rdy) bus.out_ready = 1'($urandom_range(1));
        @(negedge clk);
        accepted = 1'b0;
        if (!rst) begin
            check("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
            check("metric_valid", bus.metric_valid, mv_exp);
            if (mv_exp) check("metric", bus.metric, metric_exp);
            mv_exp = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    outs++;
                    check("out_bits", bus.out_bits, e.bits);
                    check("out_re", $signed(bus.out_re), e.re);
                    check("out_im", $signed(bus.out_im), e.im);
                    check("out_err", bus.out_err, e.err);
                    check("out_last", bus.out_last, e.last);
                    if (chk_lat) check("latency", cyc - e.acc_cyc, 2);
                    s = acc_m + e.err;
                    if (s > 64'sd4294967295) s = 64'sd4294967295;
                    if (e.last) begin
                        metric_exp = s; mv_exp = 1'b1; acc_m = 0;
                    end else begin
                        acc_m = s;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                accepted = 1'b1;
                e = pend;
                e.acc_cyc = cyc;
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        if (rst) begin
            exp_q.delete(); acc_m = 0; mv_exp = 1'b0;
        end
        #1;
        cyc++;
    endtask

    task automatic send(input int re, input int im, input logic [1:0] mode,
                        input logic last, input exp_t e);
        int t;
        bus.in_re = 22'(re); bus.in_im = 22'(im);
        bus.in_mode = mode; bus.in_last = last;
        bus.in_valid = 1'b1;
        pend = e;
        t = 0;
        do begin
            cycle();
            t++;
        end while (!accepted && t < 40);
        if (!accepted) check("accept_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_m(input int re, input int im, input logic [1:0] mode,
                          input logic last);
        send(re, im, mode, last, model(re, im, mode, last));
    endtask

    task automatic drain();
        int t;
        bus.in_valid = 1'b0;
        t = 0;
        while ((exp_q.size() != 0 || mv_exp) && t < 100) begin
            cycle();
            t++;
        end
        if (exp_q.size() != 0 || mv_exp) check("drain_timeout", 0, 1);
    endtask

    function automatic int rand_val();
        if ($urandom_range(3) == 0) return (2 * int'($urandom_range(6)) - 6) * A_C;
        return int'($urandom_range(2600)) - 1300;
    endfunction

    initial begin
        bus.in_valid = 1'b0; bus.in_re = '0; bus.in_im = '0;
        bus.in_mode = 2'b00; bus.in_last = 1'b0; bus.out_ready = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_metric_valid", bus.metric_valid, 0);
        check("rst_metric", bus.metric, 0);
        check("rst_out_bits", bus.out_bits, 0);
        check("rst_out_err", bus.out_err, 0);
        rst = 1'b0;
        check("in_ready_after_rst", bus.in_ready, 1);

        // Directed points with known answers and 2-cycle latency
        bus.out_ready = 1'b1;
        chk_lat = 1'b1;
        send(-400, 400, 2'b01, 1'b0, mk(6'b000000, -483, 483, 166, 1'b0));
        drain();
        send(322, -322, 2'b01, 1'b0, mk(6'b001011, 483, -161, 322, 1'b0));
        drain();
        send(0, 0, 2'b01, 1'b0, mk(6'b001101, 161, 161, 322, 1'b0));
        drain();
        send(1000, -1300, 2'b10, 1'b0, mk(6'b100100, 1127, -1127, 300, 1'b0));
        drain();
        send(-5, -5, 2'b00, 1'b1, mk(6'b000001, -161, -161, 312, 1'b1));
        drain();
        check("frame0_metric", bus.metric, 1422);

        // Two-sample frame back to back, then a frame that must start from zero
        send(-400, 400, 2'b01, 1'b0, mk(6'b000000, -483, 483, 166, 1'b0));
        send(1000, -1300, 2'b10, 1'b1, mk(6'b100100, 1127, -1127, 300, 1'b1));
        drain();
        check("frame1_metric", bus.metric, 466);
        send(0, 0, 2'b11, 1'b1, mk(6'b001101, 161, 161, 322, 1'b1));
        drain();
        check("frame2_metric", bus.metric, 322);

        // Random stream with random out_ready, including full-scale inputs
        chk_lat = 1'b0;
        rand_rdy = 1'b1;
        outs = 0;
        send_m(-2097152, 2097151, 2'b10, 1'b0);
        for (int i = 1; i < 16; i++) begin
            send_m(rand_val(), rand_val(), 2'($urandom_range(3)), (i == 7 || i == 15));
        end
        drain();
        rand_rdy = 1'b0;
        bus.out_ready = 1'b1;
        check("rand_count", outs, 16);

        // Reset with two samples in flight and a nonzero partial metric
        for (int i = 0; i < 4; i++) send_m(rand_val(), rand_val(), 2'b01, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_metric_valid", bus.metric_valid, 0);
        send(-400, 400, 2'b01, 1'b1, mk(6'b000000, -483, 483, 166, 1'b1));
        drain();
        check("post_rst_metric", bus.metric, 166);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
